// File: rtl/mips_mem_arbiter.sv
// Shares one single-port word RAM between an AXI-Lite slave port and the CPU data port.
// One grant in flight at a time; AXI and CPU alternate on contention.
module mips_mem_arbiter #(
  parameter int ADDR_W = 14
) (
  input  logic              mips_cpu_clk,
  input  logic              mips_cpu_reset,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       wdata,
  input  logic [3:0]        wstrb,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  output logic [31:0]       rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic              cpu_mem_req,
  input  logic              cpu_mem_wen,
  input  logic [ADDR_W-1:0] cpu_mem_addr,
  input  logic [31:0]       cpu_mem_wdata,
  input  logic [3:0]        cpu_mem_wstrb,
  output logic [31:0]       cpu_mem_rdata,
  output logic              cpu_mem_ack,
  output logic              mem_en,
  output logic [3:0]        mem_wen,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  // state     | meaning
  // IDLE      | grant decision point
  // AXI_WR    | RAM write of the latched AXI beat
  // AXI_B     | write response held until bready
  // AXI_RD    | RAM read at the latched AXI address
  // AXI_RWAIT | capture RAM read data
  // AXI_R     | read response held until rready
  // CPU_ACC   | RAM access from the CPU port (write acks here)
  // CPU_RWAIT | CPU read data returned with ack
  typedef enum logic [2:0] {
    IDLE, AXI_WR, AXI_B, AXI_RD, AXI_RWAIT, AXI_R, CPU_ACC, CPU_RWAIT
  } state_t;

  localparam logic GRANT_CPU = 1'b0;
  localparam logic GRANT_AXI = 1'b1;

  state_t            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-3:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       rdata_q, rdata_d;

  logic axi_wr_req, axi_req, grant_axi, grant_cpu;
  logic unused_byte_offsets;

  assign unused_byte_offsets = ^{araddr[1:0], awaddr[1:0], cpu_mem_addr[1:0]};

  // Reset gates the grant so IDLE never handshakes while reset is held.
  always_comb begin
    axi_wr_req = awvalid && wvalid;
    axi_req    = axi_wr_req || arvalid;
    grant_axi  = mips_cpu_reset && axi_req && (!cpu_mem_req || (last_grant_q == GRANT_CPU));
    grant_cpu  = mips_cpu_reset && cpu_mem_req && !grant_axi;
  end

  always_ff @(posedge mips_cpu_clk or negedge mips_cpu_reset) begin
    if (!mips_cpu_reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_CPU;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rdata_d       = rdata_q;
    arready       = 1'b0;
    awready       = 1'b0;
    wready        = 1'b0;
    bvalid        = 1'b0;
    rvalid        = 1'b0;
    cpu_mem_ack   = 1'b0;
    cpu_mem_rdata = '0;
    mem_en        = 1'b0;
    mem_wen       = '0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state_q)
      IDLE: begin
        if (grant_axi) begin
          last_grant_d = GRANT_AXI;
          if (axi_wr_req) begin
            awready = 1'b1;
            wready  = 1'b1;
            addr_d  = awaddr[ADDR_W-1:2];
            wdata_d = wdata;
            wstrb_d = wstrb;
            state_d = AXI_WR;
          end else begin
            arready = 1'b1;
            addr_d  = araddr[ADDR_W-1:2];
            state_d = AXI_RD;
          end
        end else if (grant_cpu) begin
          last_grant_d = GRANT_CPU;
          state_d      = CPU_ACC;
        end
      end
      AXI_WR: begin
        mem_en    = 1'b1;
        mem_wen   = wstrb_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        state_d   = AXI_B;
      end
      AXI_B: begin
        bvalid = 1'b1;
        if (bready) state_d = IDLE;
      end
      AXI_RD: begin
        mem_en   = 1'b1;
        mem_addr = addr_q;
        state_d  = AXI_RWAIT;
      end
      AXI_RWAIT: begin
        rdata_d = mem_rdata;
        state_d = AXI_R;
      end
      AXI_R: begin
        rvalid = 1'b1;
        if (rready) state_d = IDLE;
      end
      CPU_ACC: begin
        mem_en    = 1'b1;
        mem_addr  = cpu_mem_addr[ADDR_W-1:2];
        mem_wdata = cpu_mem_wdata;
        if (cpu_mem_wen) begin
          mem_wen     = cpu_mem_wstrb;
          cpu_mem_ack = 1'b1;
          state_d     = IDLE;
        end else begin
          state_d = CPU_RWAIT;
        end
      end
      CPU_RWAIT: begin
        cpu_mem_ack   = 1'b1;
        cpu_mem_rdata = mem_rdata;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign rdata = rdata_q;
  assign bresp = 2'b00;
  assign rresp = 2'b00;

endmodule

// File: tb/tb_mips_mem_arbiter.sv
// Bench for mips_mem_arbiter: RAM model, transaction-timeline reference model checked
// every cycle, and directed scenarios with hand-computed expectations.
module tb_mips_mem_arbiter;
  localparam int AW  = 14;
  localparam int NW  = 1 << (AW - 2);
  localparam int TMO = 50;
  localparam int K_AW = 0, K_AR = 1, K_CW = 2, K_CR = 3;

  logic          clk, rst_n;
  logic [AW-1:0] araddr, awaddr, cpu_mem_addr;
  logic          arvalid, arready, awvalid, awready, wvalid, wready;
  logic [31:0]   wdata, rdata, cpu_mem_wdata, cpu_mem_rdata, mem_wdata, mem_rdata;
  logic [3:0]    wstrb, cpu_mem_wstrb, mem_wen;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, rvalid, rready;
  logic          cpu_mem_req, cpu_mem_wen, cpu_mem_ack, mem_en;
  logic [AW-3:0] mem_addr;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  mips_mem_arbiter #(.ADDR_W(AW)) dut (
    .mips_cpu_clk(clk), .mips_cpu_reset(rst_n),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .cpu_mem_req(cpu_mem_req), .cpu_mem_wen(cpu_mem_wen), .cpu_mem_addr(cpu_mem_addr),
    .cpu_mem_wdata(cpu_mem_wdata), .cpu_mem_wstrb(cpu_mem_wstrb),
    .cpu_mem_rdata(cpu_mem_rdata), .cpu_mem_ack(cpu_mem_ack),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Single-port RAM, registered read.
  logic [31:0] ram [0:NW-1];
  always @(posedge clk) begin
    if (mem_en) begin
      for (int b = 0; b < 4; b++)
        if (mem_wen[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tmo(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout expected handshake at t=%0t", name, $time);
  endtask

  // Reference model: memory contents plus the per-transaction timeline after a grant.
  logic [31:0]   shadow [0:NW-1];
  logic          m_busy, m_last_axi, m_axi_w, m_axi, m_give_axi, m_give_cpu;
  logic          exp_en, exp_b, exp_r, exp_ack, m_done;
  logic [3:0]    exp_wen, m_wstrb;
  logic [AW-3:0] m_addr;
  logic [31:0]   m_wdata, m_rexp;
  int            m_kind, m_k;

  task automatic shadow_write(input logic [AW-3:0] a, input logic [31:0] d, input logic [3:0] s);
    for (int b = 0; b < 4; b++)
      if (s[b]) shadow[a][b*8 +: 8] = d[b*8 +: 8];
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_arready", 32'(arready), 0);
      chk("rst_awready", 32'(awready), 0);
      chk("rst_wready", 32'(wready), 0);
      chk("rst_bvalid", 32'(bvalid), 0);
      chk("rst_rvalid", 32'(rvalid), 0);
      chk("rst_ack", 32'(cpu_mem_ack), 0);
      chk("rst_mem_en", 32'(mem_en), 0);
      chk("rst_mem_wen", 32'(mem_wen), 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_cpu_rdata", cpu_mem_rdata, 0);
      chk("rst_resp", 32'({bresp, rresp}), 0);
      m_busy = 0;
      m_last_axi = 0;
    end else if (!m_busy) begin
      m_axi_w    = awvalid && wvalid;
      m_axi      = m_axi_w || arvalid;
      m_give_axi = m_axi && !(cpu_mem_req && m_last_axi);
      m_give_cpu = cpu_mem_req && !m_give_axi;
      chk("idle_awready", 32'(awready), 32'(m_give_axi && m_axi_w));
      chk("idle_wready", 32'(wready), 32'(m_give_axi && m_axi_w));
      chk("idle_arready", 32'(arready), 32'(m_give_axi && !m_axi_w));
      chk("idle_mem_en", 32'(mem_en), 0);
      chk("idle_mem_wen", 32'(mem_wen), 0);
      chk("idle_valids", 32'({bvalid, rvalid, cpu_mem_ack}), 0);
      if (m_give_axi) begin
        m_busy = 1; m_k = 0; m_last_axi = 1;
        if (m_axi_w) begin
          m_kind = K_AW; m_addr = awaddr[AW-1:2]; m_wdata = wdata; m_wstrb = wstrb;
          shadow_write(m_addr, wdata, wstrb);
        end else begin
          m_kind = K_AR; m_addr = araddr[AW-1:2]; m_rexp = shadow[araddr[AW-1:2]];
        end
      end else if (m_give_cpu) begin
        m_busy = 1; m_k = 0; m_last_axi = 0;
        m_addr = cpu_mem_addr[AW-1:2]; m_wdata = cpu_mem_wdata; m_wstrb = cpu_mem_wstrb;
        if (cpu_mem_wen) begin
          m_kind = K_CW;
          shadow_write(m_addr, cpu_mem_wdata, cpu_mem_wstrb);
        end else begin
          m_kind = K_CR;
          m_rexp = shadow[m_addr];
        end
      end
    end else begin
      m_k++;
      exp_en = 0; exp_wen = 0; exp_b = 0; exp_r = 0; exp_ack = 0; m_done = 0;
      case (m_kind)
        K_AW: if (m_k == 1) begin exp_en = 1; exp_wen = m_wstrb; end
              else begin exp_b = 1; m_done = bready; end
        K_AR: if (m_k == 1) exp_en = 1;
              else if (m_k >= 3) begin exp_r = 1; m_done = rready; end
        K_CW: begin exp_en = 1; exp_wen = m_wstrb; exp_ack = 1; m_done = 1; end
        default: if (m_k == 1) exp_en = 1;
                 else begin exp_ack = 1; m_done = 1; end
      endcase
      chk("busy_readies", 32'({arready, awready, wready}), 0);
      chk("mem_en", 32'(mem_en), 32'(exp_en));
      chk("mem_wen", 32'(mem_wen), 32'(exp_wen));
      chk("bvalid", 32'(bvalid), 32'(exp_b));
      chk("rvalid", 32'(rvalid), 32'(exp_r));
      chk("cpu_ack", 32'(cpu_mem_ack), 32'(exp_ack));
      if (exp_en) chk("mem_addr", 32'(mem_addr), 32'(m_addr));
      if (exp_wen != 0) chk("mem_wdata", mem_wdata, m_wdata);
      if (exp_b) chk("bresp", 32'(bresp), 0);
      if (exp_r) begin
        chk("rresp", 32'(rresp), 0);
        chk("rdata", rdata, m_rexp);
      end
      if (exp_ack && m_kind == K_CR) chk("cpu_rdata", cpu_mem_rdata, m_rexp);
      if (m_done) m_busy = 0;
    end
  end

  // All transaction tasks start and end at posedge+1.
  task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int wv_delay, input int b_delay, output int t_grant, output int t_resp,
                           output logic [AW-3:0] seen_addr, output logic [3:0] seen_wen, output int early);
    bit ok;
    early = 0; t_grant = -1; t_resp = -1; seen_addr = '0; seen_wen = '0;
    awaddr = a; awvalid = 1; wdata = d; wstrb = s;
    for (int i = 0; i < wv_delay; i++) begin
      @(negedge clk);
      if (awready || wready) early++;
      @(posedge clk); #1;
    end
    wvalid = 1;
    ok = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (awready && wready) begin ok = 1; t_grant = cyc; break; end
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    if (!ok) begin tmo("aw_handshake"); return; end
    @(negedge clk);
    seen_addr = mem_addr; seen_wen = mem_wen;
    ok = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (bvalid) begin ok = 1; t_resp = cyc; break; end
    end
    if (!ok) begin tmo("bvalid_wait"); @(posedge clk); #1; return; end
    repeat (b_delay) @(negedge clk);
    @(posedge clk); #1; bready = 1;
    @(negedge clk);
    @(posedge clk); #1; bready = 0;
  endtask

  task automatic axi_read(input logic [AW-1:0] a, input int r_delay, output int t_grant,
                          output int t_valid, output int t_hs, output logic [31:0] d, output int held);
    bit ok;
    t_grant = -1; t_valid = -1; t_hs = -1; d = '0; held = 0;
    araddr = a; arvalid = 1;
    ok = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; t_grant = cyc; break; end
    end
    @(posedge clk); #1;
    arvalid = 0;
    if (!ok) begin tmo("ar_handshake"); return; end
    ok = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (rvalid) begin ok = 1; t_valid = cyc; break; end
    end
    if (!ok) begin tmo("rvalid_wait"); @(posedge clk); #1; return; end
    held = 1;
    for (int i = 1; i < r_delay; i++) begin
      @(negedge clk);
      if (rvalid) held++;
    end
    @(posedge clk); #1; rready = 1;
    @(negedge clk);
    t_hs = cyc; d = rdata;
    @(posedge clk); #1; rready = 0;
  endtask

  task automatic cpu_access(input logic wen, input logic [AW-1:0] a, input logic [31:0] d,
                            input logic [3:0] s, output int t_ack, output logic [31:0] rd);
    bit ok;
    t_ack = -1; rd = '0;
    cpu_mem_req = 1; cpu_mem_wen = wen; cpu_mem_addr = a; cpu_mem_wdata = d; cpu_mem_wstrb = s;
    ok = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (cpu_mem_ack) begin ok = 1; t_ack = cyc; rd = cpu_mem_rdata; break; end
    end
    if (!ok) tmo("cpu_ack_wait");
    @(posedge clk); #1;
    cpu_mem_req = 0; cpu_mem_wen = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish by t=%0t", $time);
    $fatal(1, "watchdog expired");
  end

  int tg, tv, th, tr, ta, er, held, cnt;
  int ag [3];
  int ca [3];
  logic [31:0]   rd, rd2;
  logic [AW-3:0] sa;
  logic [3:0]    sw;
  bit            ok;

  initial begin
    clk = 0; rst_n = 1;
    araddr = '0; arvalid = 0; awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    bready = 0; rready = 0; cpu_mem_req = 0; cpu_mem_wen = 0; cpu_mem_addr = '0;
    cpu_mem_wdata = '0; cpu_mem_wstrb = '0; mem_rdata = '0;
    m_busy = 0; m_last_axi = 0; m_kind = 0; m_k = 0;
    for (int i = 0; i < NW; i++) begin ram[i] = '0; shadow[i] = '0; end
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    axi_write(14'h0010, 32'hDEADBEEF, 4'hF, 0, 0, tg, tr, sa, sw, er);
    chk("wr_bvalid_latency", 32'(tr - tg), 2);
    chk("wr_mem_addr", 32'(sa), 4);
    chk("wr_mem_wen", 32'(sw), 32'hF);

    axi_read(14'h0010, 5, tg, tv, th, rd, held);
    chk("rd_rvalid_latency", 32'(tv - tg), 3);
    chk("rd_data", rd, 32'hDEADBEEF);
    chk("rd_held_cycles", 32'(held), 5);

    axi_write(14'h0020, 32'h11223344, 4'hF, 0, 1, tg, tr, sa, sw, er);
    cpu_access(1'b1, 14'h0020, 32'h0000AB00, 4'b0010, ta, rd);
    cpu_access(1'b0, 14'h0020, 32'h0, 4'h0, ta, rd);
    chk("cpu_byte1_merge", rd, 32'h1122AB44);
    cpu_access(1'b0, 14'h0023, 32'h0, 4'h0, ta, rd);
    chk("cpu_addr_lsbs_ignored", rd, 32'h1122AB44);

    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    fork
      axi_read(14'h0010, 1, tg, tv, th, rd, held);
      cpu_access(1'b0, 14'h0020, 32'h0, 4'h0, ta, rd2);
    join
    chk("tie1_axi_first", 32'(ta > tg), 1);
    chk("tie1_cpu_ack_after_rready", 32'(ta - th), 3);
    chk("tie1_axi_data", rd, 32'hDEADBEEF);
    chk("tie1_cpu_data", rd2, 32'h1122AB44);
    fork
      axi_read(14'h0020, 1, tg, tv, th, rd, held);
      cpu_access(1'b0, 14'h0010, 32'h0, 4'h0, ta, rd2);
    join
    chk("tie2_axi_first", 32'(ta > tg), 1);
    chk("tie2_axi_data", rd, 32'h1122AB44);

    fork
      axi_write(14'h0030, 32'hCAFEF00D, 4'hF, 4, 0, tg, tr, sa, sw, er);
      cpu_access(1'b1, 14'h0040, 32'h55AA55AA, 4'hF, ta, rd2);
    join
    chk("no_aw_without_w", 32'(er), 0);
    chk("cpu_served_while_aw_waits", 32'(ta < tg), 1);
    chk("aw_late_mem_addr", 32'(sa), 12);
    cpu_access(1'b0, 14'h0030, 32'h0, 4'h0, ta, rd);
    chk("late_w_data", rd, 32'hCAFEF00D);
    axi_read(14'h0040, 2, tg, tv, th, rd, held);
    chk("cpu_full_write", rd, 32'h55AA55AA);

    fork
      for (int i = 0; i < 3; i++) axi_read(14'h0010, 1, ag[i], tv, th, rd, held);
      for (int i = 0; i < 3; i++) cpu_access(1'b0, 14'h0020, 32'h0, 4'h0, ca[i], rd2);
    join
    for (int i = 0; i < 3; i++) begin
      chk("alt_cpu_before_axi", 32'(ca[i] < ag[i]), 1);
      if (i > 0) chk("alt_axi_before_next_cpu", 32'(ag[i-1] < ca[i]), 1);
    end

    araddr = 14'h0010; arvalid = 1;
    ok = 0;
    for (int i = 0; i < TMO; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1; break; end
    end
    if (!ok) tmo("rst_rd_grant");
    @(posedge clk); #1 arvalid = 0;
    @(posedge clk); #2 rst_n = 0;
    #1;
    chk("async_rst_rvalid", 32'(rvalid), 0);
    chk("async_rst_mem_en", 32'(mem_en), 0);
    chk("async_rst_rdata", rdata, 0);
    chk("async_rst_arready", 32'(arready), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (rvalid) cnt++;
    end
    chk("no_rvalid_after_abort", 32'(cnt), 0);
    @(posedge clk); #1;
    fork
      axi_read(14'h0010, 1, tg, tv, th, rd, held);
      cpu_access(1'b0, 14'h0030, 32'h0, 4'h0, ta, rd2);
    join
    chk("post_rst_tie_axi_first", 32'(ta > tg), 1);
    chk("post_rst_axi_data", rd, 32'hDEADBEEF);
    chk("post_rst_cpu_data", rd2, 32'hCAFEF00D);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mips_mem_arbiter.md
MIPS_MEM_ARBITER -- requirements
Module: mips_mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 14, byte-address width of the AXI and CPU ports.
REQ-002 SHALL have port mips_cpu_clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port mips_cpu_reset, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have AXI-Lite AR ports: araddr in ADDR_W, arvalid in 1, arready out 1.
REQ-005 SHALL have AXI-Lite AW/W ports: awaddr in ADDR_W, awvalid in 1, awready out 1, wdata in 32, wstrb in 4, wvalid in 1, wready out 1.
REQ-006 SHALL have AXI-Lite B/R ports: bresp out 2, bvalid out 1, bready in 1, rdata out 32, rresp out 2, rvalid out 1, rready in 1.
REQ-007 SHALL have CPU data-port ports: cpu_mem_req in 1, cpu_mem_wen in 1, cpu_mem_addr in ADDR_W, cpu_mem_wdata in 32, cpu_mem_wstrb in 4, cpu_mem_rdata out 32, cpu_mem_ack out 1.
REQ-008 SHALL have single-port RAM ports: mem_en out 1, mem_wen out 4, mem_addr out ADDR_W-2 (word address), mem_wdata out 32, mem_rdata in 32 (valid one cycle after a read with mem_en=1).

Function
REQ-009 SHALL implement FSM states IDLE, AXI_WR, AXI_B, AXI_RD, AXI_RWAIT, AXI_R, CPU_ACC, CPU_RWAIT; one grant in flight at a time.
REQ-010 SHALL decide grants only in IDLE; AXI request = (awvalid && wvalid) || arvalid; CPU request = cpu_mem_req.
REQ-011 SHALL arbitrate AXI vs CPU round-robin via a last_grant bit: on a tie, grant the side not granted last; last_grant resets to CPU, so AXI wins the first tie.
REQ-012 SHALL, within AXI, give write priority over read when both are pending.
REQ-013 SHALL never accept awvalid without wvalid, or the reverse; awready and wready pulse together for one cycle.
REQ-014 SHALL, on an AXI write grant (cycle 0): pulse awready=wready=1 and latch awaddr/wdata/wstrb; cycle 1 (AXI_WR): mem_en=1, mem_wen=wstrb, mem_addr=awaddr[ADDR_W-1:2]; cycle 2 onward (AXI_B): bvalid=1, bresp=2'b00, held until bready, then IDLE.
REQ-015 SHALL, on an AXI read grant (cycle 0): pulse arready=1 and latch araddr; cycle 1 (AXI_RD): mem_en=1, mem_wen=0; cycle 2 (AXI_RWAIT): register mem_rdata; cycle 3 onward (AXI_R): rvalid=1, rresp=2'b00, rdata stable, held until rready, then IDLE.
REQ-016 SHALL, on a CPU grant: cycle 1 (CPU_ACC): mem_en=1, mem_wen = cpu_mem_wen ? cpu_mem_wstrb : 4'b0; on a write, pulse cpu_mem_ack in CPU_ACC then IDLE; on a read, go to CPU_RWAIT and pulse cpu_mem_ack with cpu_mem_rdata=mem_rdata, then IDLE.
REQ-017 SHALL require cpu_mem_req and its fields to stay stable until cpu_mem_ack; a req dropped before ack is out of protocol and is not checked.
REQ-018 SHALL ignore address bits [1:0]; the full ADDR_W range is valid, so bresp and rresp are always OKAY.
REQ-019 SHALL drive mem_en=0 and mem_wen=0 in every state other than AXI_WR, AXI_RD and CPU_ACC.
REQ-020 SHALL, with both sides requesting continuously, alternate grants AXI, CPU, AXI, ...; no requester waits more than one other transaction.
REQ-021 SHALL take a new grant on the IDLE cycle directly after bready/rready/ack completion; there are no idle bubbles beyond IDLE itself.

Reset
REQ-022 SHALL, while mips_cpu_reset=0: set FSM=IDLE, last_grant=CPU, and drive all ready, valid, ack, mem_en and mem_wen to 0, and rdata, cpu_mem_rdata, bresp and rresp to 0.
REQ-023 SHALL abort any in-flight transaction on reset assertion, with no memory write completing after the reset edge and no response issued afterwards.

Verification
REQ-024 SHALL cover AXI write of 0xDEADBEEF, wstrb=4'hF, to 0x0010 -> awready/wready at cycle 0; mem_wen=F, mem_addr=4 at cycle 1; bvalid at cycle 2.
REQ-025 SHALL cover AXI read of 0x0010 after REQ-024 -> arready at cycle 0; rvalid at cycle 3 with rdata=0xDEADBEEF, held with rready=0 for 5 cycles.
REQ-026 SHALL cover a simultaneous AXI read and CPU read out of reset -> AXI granted first, CPU ack follows immediately after rready; the next tie goes to AXI.
REQ-027 SHALL cover a CPU write with wstrb=4'b0010 of 0x0000AB00 to 0x0020 -> only byte 1 is written, and a CPU read then returns 0x..AB.. on cpu_mem_ack.
REQ-028 SHALL cover awvalid=1 with wvalid=0 for 4 cycles -> no awready; a CPU request is granted meanwhile; awready/wready follow once wvalid=1.
REQ-029 SHALL cover reset asserted in AXI_RWAIT -> all outputs 0 asynchronously, rvalid never asserted, FSM=IDLE after release.
